// File: rtl/frame_capture_ctrl_pkg.sv
// Shared types and default sizing for the frame capture controller.
//   state_e          : controller states (IDLE, CAPTURE, DONE)
//   DEF_FRAME_BITS   : default bits per frame
//   DEF_TIMEOUT_CYC  : default stall limit, in clk cycles between strobes
package frame_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int DEF_FRAME_BITS  = 51;
  localparam int DEF_TIMEOUT_CYC = 4096;

endpackage

// File: rtl/frame_capture_ctrl_if.sv
// Bus bundle between the serial-bit source / frame consumer and the
// capture controller.
//   start, bit_strobe, bit_in, frame_ready       : source/consumer -> controller
//   frame_data, frame_valid, busy, bit_count,
//   timeout_err, overrun                         : controller -> source/consumer
// Modports: master = source/consumer side, slave = controller side.
interface frame_capture_ctrl_if
  import frame_capture_ctrl_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS
);
  localparam int CW = $clog2(FRAME_BITS + 1);

  logic                  start;
  logic                  bit_strobe;
  logic                  bit_in;
  logic                  frame_ready;
  logic [FRAME_BITS-1:0] frame_data;
  logic                  frame_valid;
  logic                  busy;
  logic [CW-1:0]         bit_count;
  logic                  timeout_err;
  logic                  overrun;

  modport master (
    output start, bit_strobe, bit_in, frame_ready,
    input  frame_data, frame_valid, busy, bit_count, timeout_err, overrun
  );

  modport slave (
    input  start, bit_strobe, bit_in, frame_ready,
    output frame_data, frame_valid, busy, bit_count, timeout_err, overrun
  );

endinterface

// File: rtl/frame_capture_ctrl_stall_timer.sv
// Gap counter that measures clk cycles since the last accepted bit.
//   clk, reset : clock, synchronous active-high reset
//   clr        : zero the counter (takes priority over en)
//   en         : count this cycle
//   tc         : counter sits at TIMEOUT_CYC-1
// The counter parks at TIMEOUT_CYC-1 so it never exceeds the limit.
module stall_timer
  import frame_capture_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int GW = $clog2(TIMEOUT_CYC);

  logic [GW-1:0] gap_q, gap_d;

  assign tc = (gap_q == GW'(TIMEOUT_CYC - 1));

  always_comb begin
    gap_d = gap_q;
    if (clr)
      gap_d = '0;
    else if (en && !tc)
      gap_d = gap_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      gap_q <= '0;
    else
      gap_q <= gap_d;
  end

endmodule

// File: rtl/frame_capture_ctrl.sv
// Serial-bit frame capture controller. Arms on start, shifts one bit per
// strobe (first bit ends up in the MSB), hands the full frame to a consumer
// over valid/ready, and aborts if the bit stream stalls.
//   clk, reset : clock, synchronous active-high reset
//   bus        : frame_capture_ctrl_if slave modport (see interface header)
//
// state   | meaning
// IDLE    | waiting for start; strobes ignored
// CAPTURE | shifting in bits, stall timer running
// DONE    | full frame held until frame_ready
module frame_capture_ctrl
  import frame_capture_ctrl_pkg::*;
#(
  parameter int FRAME_BITS  = DEF_FRAME_BITS,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 reset,
  frame_capture_ctrl_if.slave  bus
);
  localparam int CW = $clog2(FRAME_BITS + 1);

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] frame_data_q, frame_data_d;
  logic [CW-1:0]         bit_count_q, bit_count_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  overrun_q, overrun_d;
  logic                  busy_q, busy_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  gap_tc;

  // Gap counting only matters in CAPTURE; any start or strobe restarts it.
  stall_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_stall_timer (
    .clk   (clk),
    .reset (reset),
    .clr   ((state_q != CAPTURE) || bus.start || bus.bit_strobe),
    .en    (state_q == CAPTURE),
    .tc    (gap_tc)
  );

  always_comb begin
    state_d       = state_q;
    frame_data_d  = frame_data_q;
    bit_count_d   = bit_count_q;
    timeout_err_d = timeout_err_q;
    overrun_d     = overrun_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d       = CAPTURE;
          frame_data_d  = '0;
          bit_count_d   = '0;
          timeout_err_d = 1'b0;
          overrun_d     = 1'b0;
        end
      end

      CAPTURE: begin
        // start beats a simultaneous strobe; that bit is dropped.
        if (bus.start) begin
          frame_data_d = '0;
          bit_count_d  = '0;
        end else if (bus.bit_strobe) begin
          frame_data_d = {frame_data_q[FRAME_BITS-2:0], bus.bit_in};
          if (bit_count_q != CW'(FRAME_BITS))
            bit_count_d = bit_count_q + 1'b1;
          if (bit_count_q == CW'(FRAME_BITS - 1))
            state_d = DONE;
        end else if (gap_tc) begin
          // Partial frame and count are left visible for diagnosis.
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end
      end

      DONE: begin
        if (bus.bit_strobe)
          overrun_d = 1'b1;
        if (bus.frame_ready) begin
          if (bus.start) begin
            state_d       = CAPTURE;
            frame_data_d  = '0;
            bit_count_d   = '0;
            timeout_err_d = 1'b0;
            overrun_d     = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d        = (state_d == CAPTURE);
    frame_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      frame_data_q  <= '0;
      bit_count_q   <= '0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_data_q  <= frame_data_d;
      bit_count_q   <= bit_count_d;
      timeout_err_q <= timeout_err_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign bus.frame_data  = frame_data_q;
  assign bus.bit_count   = bit_count_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.overrun     = overrun_q;
  assign bus.busy        = busy_q;
  assign bus.frame_valid = frame_valid_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
module tb_frame_capture_ctrl;
  localparam int FB = 8;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [FB-1:0] exp_q[$];
  logic [FB-1:0] exp;

  always #5 clk = ~clk;

  frame_capture_ctrl_if #(.FRAME_BITS(FB)) bus ();

  frame_capture_ctrl #(.FRAME_BITS(FB), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b);
    bus.bit_strobe = 1'b1;
    bus.bit_in     = b;
    cyc();
    bus.bit_strobe = 1'b0;
    bus.bit_in     = 1'b0;
  endtask

  // First bit sent lands in the MSB, so sending f MSB-first reproduces f.
  task automatic send_frame(input logic [FB-1:0] f);
    for (int i = FB - 1; i >= 0; i--) strobe(f[i]);
    exp_q.push_back(f);
  endtask

  task automatic pop_exp();
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected frame queued");
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b1; bus.bit_strobe = 1'b1; bus.bit_in = 1'b1; bus.frame_ready = 1'b1;
    cyc(); cyc();
    bus.start = 1'b0; bus.bit_strobe = 1'b0; bus.bit_in = 1'b0; bus.frame_ready = 1'b0;
    checks++; if (bus.frame_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 00", bus.frame_data); end
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.frame_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.bit_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.bit_count); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b want 0", bus.timeout_err); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", bus.overrun); end
    reset = 1'b0;
    cyc();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_no_start_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_basic_frame();
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", bus.busy); end
    send_frame(8'hB2);
    pop_exp();
    checks++; if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", bus.frame_valid); end
    checks++; if (bus.frame_data !== exp) begin errors++; $display("FAIL basic_data: got %h want %h", bus.frame_data, exp); end
    checks++; if (bus.frame_data !== 8'hB2) begin errors++; $display("FAIL basic_data_b2: got %h want b2", bus.frame_data); end
    checks++; if (bus.bit_count !== 4'd8) begin errors++; $display("FAIL basic_count: got %0d want 8", bus.bit_count); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b want 0", bus.busy); end
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++; if (bus.frame_data !== 8'hB2 || bus.frame_valid !== 1'b1) begin errors++; $display("FAIL basic_hold: cyc %0d got %h/%b want b2/1", i, bus.frame_data, bus.frame_valid); end
    end
    bus.frame_ready = 1'b1; cyc(); bus.frame_ready = 1'b0;
    checks++; if (bus.frame_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL basic_handshake: got valid %b busy %b want 0 0", bus.frame_valid, bus.busy); end
    checks++; if (bus.frame_data !== 8'hB2) begin errors++; $display("FAIL basic_idle_hold: got %h want b2", bus.frame_data); end
  endtask

  task automatic test_done_start();
    logic [FB-1:0] f;
    f = FB'($urandom_range(1, 255));
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    send_frame(f);
    pop_exp();
    checks++; if (bus.frame_valid !== 1'b1 || bus.frame_data !== exp) begin errors++; $display("FAIL ds_frame: got %h/%b want %h/1", bus.frame_data, bus.frame_valid, exp); end
    bus.start = 1'b1; bus.frame_ready = 1'b1; cyc(); bus.start = 1'b0; bus.frame_ready = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.frame_valid !== 1'b0) begin errors++; $display("FAIL ds_restart: got busy %b valid %b want 1 0", bus.busy, bus.frame_valid); end
    checks++; if (bus.bit_count !== '0 || bus.frame_data !== '0) begin errors++; $display("FAIL ds_clear: got cnt %0d data %h want 0 00", bus.bit_count, bus.frame_data); end
  endtask

  task automatic test_overrun();
    send_frame(8'h5C);
    pop_exp();
    checks++; if (bus.frame_valid !== 1'b1 || bus.frame_data !== exp) begin errors++; $display("FAIL ovr_frame: got %h/%b want %h/1", bus.frame_data, bus.frame_valid, exp); end
    strobe(1'b1);
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", bus.overrun); end
    checks++; if (bus.frame_data !== 8'h5C || bus.bit_count !== 4'd8) begin errors++; $display("FAIL ovr_data: got %h cnt %0d want 5c 8", bus.frame_data, bus.bit_count); end
    bus.start = 1'b1; cyc();
    checks++; if (bus.frame_valid !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL ovr_start_no_ready: got valid %b busy %b want 1 0", bus.frame_valid, bus.busy); end
    bus.frame_ready = 1'b1; cyc(); bus.start = 1'b0; bus.frame_ready = 1'b0;
    checks++; if (bus.overrun !== 1'b0 || bus.busy !== 1'b1 || bus.frame_data !== '0) begin errors++; $display("FAIL ovr_clear: got ovr %b busy %b data %h want 0 1 00", bus.overrun, bus.busy, bus.frame_data); end
  endtask

  task automatic test_timeout();
    strobe(1'b1); strobe(1'b0); strobe(1'b1);
    for (int i = 1; i < TO; i++) begin
      cyc();
      checks++; if (bus.busy !== 1'b1 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL to_early: stall %0d got busy %b terr %b want 1 0", i, bus.busy, bus.timeout_err); end
    end
    cyc();
    checks++; if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_fire: got busy %b terr %b want 0 1", bus.busy, bus.timeout_err); end
    checks++; if (bus.bit_count !== 4'd3 || bus.frame_data !== 8'h05) begin errors++; $display("FAIL to_partial: got cnt %0d data %h want 3 05", bus.bit_count, bus.frame_data); end
  endtask

  task automatic test_threshold_strobe();
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    checks++; if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL th_start: got terr %b busy %b want 0 1", bus.timeout_err, bus.busy); end
    strobe(1'b1); strobe(1'b1); strobe(1'b0);
    for (int i = 1; i < TO; i++) cyc();
    strobe(1'b1);
    checks++; if (bus.busy !== 1'b1 || bus.timeout_err !== 1'b0 || bus.bit_count !== 4'd4) begin errors++; $display("FAIL th_strobe: got busy %b terr %b cnt %0d want 1 0 4", bus.busy, bus.timeout_err, bus.bit_count); end
    checks++; if (bus.frame_data !== 8'h0D) begin errors++; $display("FAIL th_data: got %h want 0d", bus.frame_data); end
    for (int i = 1; i < TO; i++) cyc();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL th_gap_cleared: got busy %b want 1", bus.busy); end
    cyc();
    checks++; if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b1) begin errors++; $display("FAIL th_refire: got busy %b terr %b want 0 1", bus.busy, bus.timeout_err); end
  endtask

  task automatic test_restart();
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    for (int i = 0; i < 5; i++) strobe(1'b1);
    bus.start = 1'b1; bus.bit_strobe = 1'b1; bus.bit_in = 1'b1; cyc();
    bus.start = 1'b0; bus.bit_strobe = 1'b0; bus.bit_in = 1'b0;
    checks++; if (bus.bit_count !== '0 || bus.frame_data !== '0 || bus.busy !== 1'b1) begin errors++; $display("FAIL rs_clear: got cnt %0d data %h busy %b want 0 00 1", bus.bit_count, bus.frame_data, bus.busy); end
    send_frame(8'hAA);
    pop_exp();
    checks++; if (bus.frame_valid !== 1'b1 || bus.frame_data !== exp) begin errors++; $display("FAIL rs_frame: got %h/%b want %h/1", bus.frame_data, bus.frame_valid, exp); end
    bus.frame_ready = 1'b1; cyc(); bus.frame_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    for (int i = 0; i < 6; i++) strobe(1'b1);
    reset = 1'b1; cyc(); reset = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.bit_count !== '0 || bus.frame_data !== '0 || bus.frame_valid !== 1'b0) begin errors++; $display("FAIL rm_capture: got busy %b cnt %0d data %h valid %b want 0 0 00 0", bus.busy, bus.bit_count, bus.frame_data, bus.frame_valid); end
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    send_frame(8'h3C);
    pop_exp();
    checks++; if (bus.frame_valid !== 1'b1 || bus.frame_data !== exp) begin errors++; $display("FAIL rm_frame: got %h/%b want %h/1", bus.frame_data, bus.frame_valid, exp); end
    strobe(1'b1);
    reset = 1'b1; cyc(); reset = 1'b0;
    checks++; if (bus.frame_valid !== 1'b0 || bus.busy !== 1'b0 || bus.bit_count !== '0 || bus.frame_data !== '0 || bus.overrun !== 1'b0 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rm_done: got valid %b busy %b cnt %0d data %h ovr %b terr %b want all 0", bus.frame_valid, bus.busy, bus.bit_count, bus.frame_data, bus.overrun, bus.timeout_err); end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.bit_strobe = 1'b0; bus.bit_in = 1'b0; bus.frame_ready = 1'b0;
    test_reset();
    test_basic_frame();
    test_done_start();
    test_overrun();
    test_timeout();
    test_threshold_strobe();
    test_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
